// File: rtl/sensor_fsm_gen_if.sv
// Handshake between the sampling controller and the sensor measure FSM.
// The controller is the master: it issues start and consumes done/value.
interface sensor_fsm_gen_if #(
  parameter int VW = 16
);
  logic          start;
  logic          done;
  logic [VW-1:0] value;

  modport master (
    output start,
    input  done,
    input  value
  );

  modport slave (
    input  start,
    output done,
    output value
  );
endinterface

// File: rtl/sensor_fsm_gen.sv
// Periodic sensor-sampling controller: delta or window-exit interrupts.
// Optional transfer watchdog is built when SENSORFSM_TIMEOUT_EN is defined.
module sensor_fsm_gen #(
  parameter int DataWidth    = 8,
  parameter int NumBytes     = 2,
  parameter int TimerWidth   = 32,
  parameter int TimeoutWidth = 16,
  localparam int VW          = NumBytes * DataWidth
) (
  input  logic                    Clk_i,
  input  logic                    Reset_i,
  input  logic                    Enable_i,
  output logic                    CpuIntr_o,
  output logic [1:0]              IntrCause_o,
  output logic [VW-1:0]           SensorValue_o,
  sensor_fsm_gen_if.master        MeasureFSM,
  input  logic                    ParamMode_i,
  input  logic [VW-1:0]           ParamThreshold_i,
  input  logic [VW-1:0]           ParamThresholdLow_i,
  input  logic [TimerWidth-1:0]   ParamCounterPreset_i,
  input  logic [TimeoutWidth-1:0] ParamTimeout_i
);

  typedef enum logic [1:0] {
    ST_DIS,
    ST_IDLE,
    ST_XFER,
    ST_NOTIFY
  } state_e;

  state_e                  state_q, state_d;
  logic [TimerWidth-1:0]   timer_q, timer_d;
  logic [TimeoutWidth-1:0] wdog_q, wdog_d;
  logic [VW-1:0]           value_q, value_d;
  logic [1:0]              cause_q, cause_d;
  logic                    oow_q, oow_d;
  logic                    start_c;
  logic                    intr_c;

  // Absolute difference one bit wider so it can never wrap.
  logic [VW:0] s_ext, v_ext, diff;
  logic        outside, event_c;

  assign s_ext   = {1'b0, MeasureFSM.value};
  assign v_ext   = {1'b0, value_q};
  assign diff    = (s_ext >= v_ext) ? (s_ext - v_ext)
                                    : (v_ext - s_ext);
  assign outside = (MeasureFSM.value < ParamThresholdLow_i) ||
                   (MeasureFSM.value > ParamThreshold_i);
  assign event_c = ParamMode_i ? (outside && !oow_q)
                               : (diff > {1'b0, ParamThreshold_i});

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    wdog_d  = wdog_q;
    value_d = value_q;
    cause_d = cause_q;
    oow_d   = oow_q;
    start_c = 1'b0;
    intr_c  = 1'b0;
    unique case (state_q)
      ST_DIS: begin
        oow_d = 1'b0;
        if (Enable_i) begin
          state_d = ST_IDLE;
          timer_d = ParamCounterPreset_i;
        end
      end
      ST_IDLE: begin
        if (!Enable_i) begin
          state_d = ST_DIS;
        end else if (timer_q == '0) begin
          start_c = 1'b1;
          state_d = ST_XFER;
          wdog_d  = '0;
        end else begin
          timer_d = timer_q - TimerWidth'(1);
        end
      end
      ST_XFER: begin
        if (MeasureFSM.done) begin
          timer_d = ParamCounterPreset_i;
          state_d = ST_IDLE;
          if (ParamMode_i) oow_d = outside;
          if (event_c) begin
            value_d = MeasureFSM.value;
            cause_d = 2'b01;
            state_d = ST_NOTIFY;
          end
`ifdef SENSORFSM_TIMEOUT_EN
        end else if (ParamTimeout_i != '0 &&
                     wdog_q == ParamTimeout_i) begin
          timer_d = ParamCounterPreset_i;
          cause_d = 2'b10;
          state_d = ST_NOTIFY;
        end else begin
          wdog_d = wdog_q + TimeoutWidth'(1);
`endif
        end
      end
      ST_NOTIFY: begin
        intr_c  = 1'b1;
        state_d = ST_IDLE;
        // Saturate so a zero period keeps sampling back to back.
        if (timer_q != '0) timer_d = timer_q - TimerWidth'(1);
      end
      default: state_d = ST_DIS;
    endcase
  end

  always_ff @(posedge Clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      state_q <= ST_DIS;
      timer_q <= '0;
      wdog_q  <= '0;
      value_q <= '0;
      cause_q <= '0;
      oow_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      wdog_q  <= wdog_d;
      value_q <= value_d;
      cause_q <= cause_d;
      oow_q   <= oow_d;
    end
  end

`ifndef SENSORFSM_TIMEOUT_EN
  logic unused_tmo;
  assign unused_tmo = ^{ParamTimeout_i, wdog_q};
`endif

  assign MeasureFSM.start = start_c;
  assign CpuIntr_o        = intr_c;
  assign IntrCause_o      = cause_q;
  assign SensorValue_o    = value_q;

endmodule

// File: tb/tb_sensor_fsm_gen.sv
// Directed bench for sensor_fsm_gen (VW=16); timeout scenario only
// when SENSORFSM_TIMEOUT_EN is defined.
module tb_sensor_fsm_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        intr;
  logic [1:0]  cause;
  logic [15:0] sval;
  logic        mode = 1'b0;
  logic [15:0] thr = '0;
  logic [15:0] thr_lo = '0;
  logic [31:0] preset = '0;
  logic [15:0] tmo = '0;

  int errors = 0;
  int checks = 0;

  sensor_fsm_gen_if #(.VW(16)) mif ();

  sensor_fsm_gen dut (
    .Clk_i                (clk),
    .Reset_i              (rst),
    .Enable_i             (en),
    .CpuIntr_o            (intr),
    .IntrCause_o          (cause),
    .SensorValue_o        (sval),
    .MeasureFSM           (mif.master),
    .ParamMode_i          (mode),
    .ParamThreshold_i     (thr),
    .ParamThresholdLow_i  (thr_lo),
    .ParamCounterPreset_i (preset),
    .ParamTimeout_i       (tmo)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not end");
    $fatal(1, "global timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for Start, then returns Done after lat Xfer cycles.
  // Returns positioned in cycle d+1, settled.
  task automatic run_sample(input logic [15:0] v, input int lat,
                            output int wait_n, output bit ok);
    wait_n = 0;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      #1;
      if (mif.start) begin
        ok = 1'b1;
        break;
      end
      wait_n++;
      cyc();
    end
    if (ok) begin
      cyc();
      repeat (lat) cyc();
      mif.done = 1'b1;
      mif.value = v;
      cyc();
      mif.done = 1'b0;
      mif.value = '0;
      #1;
    end
  endtask

  task automatic go_disabled();
    en = 1'b0;
    cyc();
    cyc();
    cyc();
  endtask

  task automatic test_reset();
    mif.done = 1'b0;
    mif.value = '0;
    #2;
    checks++;
    if (intr !== 1'b0) begin
      errors++; $display("FAIL rst_intr: got %b want 0", intr);
    end
    checks++;
    if (cause !== 2'b00) begin
      errors++; $display("FAIL rst_cause: got %b want 00", cause);
    end
    checks++;
    if (sval !== 16'h0) begin
      errors++; $display("FAIL rst_sval: got %h want 0000", sval);
    end
    checks++;
    if (mif.start !== 1'b0) begin
      errors++; $display("FAIL rst_start: got %b want 0", mif.start);
    end
    cyc();
    rst = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic test_delta();
    int w;
    bit ok;
    int n;
    mode = 1'b0;
    thr = 16'd10;
    preset = 32'd3;
    en = 1'b1;
    cyc();
    n = 0;
    for (int i = 1; i <= 3; i++) begin
      #1;
      if (mif.start) n++;
      cyc();
    end
    #1;
    checks++;
    if (n !== 0 || mif.start !== 1'b1) begin
      errors++;
      $display("FAIL delta_first_start: early=%0d start@4=%b want 0,1",
               n, mif.start);
    end
    run_sample(16'h0014, 0, w, ok);
    checks++;
    if (!ok || intr !== 1'b1 || sval !== 16'h0014 || cause !== 2'b01) begin
      errors++;
      $display("FAIL delta_s1: ok=%0d intr=%b sval=%h cause=%b want 1,1,0014,01",
               ok, intr, sval, cause);
    end
    cyc();
    #1;
    checks++;
    if (intr !== 1'b0) begin
      errors++; $display("FAIL delta_pulse: got %b want 0", intr);
    end
    run_sample(16'h001A, 1, w, ok);
    checks++;
    if (!ok || w != 2 || intr !== 1'b0 || sval !== 16'h0014) begin
      errors++;
      $display("FAIL delta_s2: ok=%0d wait=%0d intr=%b sval=%h want 1,2,0,0014",
               ok, w, intr, sval);
    end
    run_sample(16'h0009, 2, w, ok);
    checks++;
    if (!ok || w != 3 || intr !== 1'b1 || sval !== 16'h0009) begin
      errors++;
      $display("FAIL delta_s3: ok=%0d wait=%0d intr=%b sval=%h want 1,3,1,0009",
               ok, w, intr, sval);
    end
    run_sample(16'h0013, 0, w, ok);
    checks++;
    if (!ok || w != 3 || intr !== 1'b0 || sval !== 16'h0009) begin
      errors++;
      $display("FAIL delta_equal_thr: ok=%0d wait=%0d intr=%b sval=%h want 1,3,0,0009",
               ok, w, intr, sval);
    end
    go_disabled();
  endtask

  task automatic test_window();
    logic [15:0] smp [5];
    logic        exp_i [5];
    logic [15:0] exp_v [5];
    int w;
    bit ok;
    smp   = '{16'd150, 16'd250, 16'd260, 16'd150, 16'd50};
    exp_i = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_v = '{16'd9, 16'd250, 16'd250, 16'd250, 16'd50};
    mode = 1'b1;
    thr_lo = 16'd100;
    thr = 16'd200;
    preset = 32'd1;
    en = 1'b1;
    cyc();
    for (int i = 0; i < 5; i++) begin
      run_sample(smp[i], 1, w, ok);
      checks++;
      if (!ok || w != 1 || intr !== exp_i[i] || sval !== exp_v[i]) begin
        errors++;
        $display("FAIL window_s%0d: ok=%0d wait=%0d intr=%b sval=%0d want 1,1,%b,%0d",
                 i, ok, w, intr, sval, exp_i[i], exp_v[i]);
      end
    end
    go_disabled();
  endtask

  task automatic test_enable_drop();
    int n;
    int w;
    bit ok;
    mode = 1'b0;
    thr = 16'd10;
    preset = 32'd5;
    en = 1'b1;
    cyc();
    cyc();
    cyc();
    en = 1'b0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (mif.start) n++;
      cyc();
    end
    checks++;
    if (n != 0) begin
      errors++; $display("FAIL drop_idle: starts=%0d want 0", n);
    end
    preset = 32'd2;
    en = 1'b1;
    cyc();
    ok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (mif.start) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    cyc();
    en = 1'b0;
    cyc();
    mif.done = 1'b1;
    mif.value = 16'd200;
    cyc();
    mif.done = 1'b0;
    mif.value = '0;
    #1;
    checks++;
    if (!ok || intr !== 1'b1 || sval !== 16'd200) begin
      errors++;
      $display("FAIL drop_xfer: ok=%0d intr=%b sval=%0d want 1,1,200",
               ok, intr, sval);
    end
    n = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      #1;
      if (mif.start || intr) n++;
    end
    checks++;
    if (n != 0) begin
      errors++; $display("FAIL drop_after: activity=%0d want 0", n);
    end
    run_sample(16'd0, 0, w, ok);
    checks++;
    if (ok) begin
      errors++; $display("FAIL drop_stays_off: start seen, want none");
    end
  endtask

`ifdef SENSORFSM_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    int w;
    bit ok;
    logic [15:0] keep;
    keep = sval;
    mode = 1'b0;
    tmo = 16'd4;
    preset = 32'd2;
    en = 1'b1;
    cyc();
    ok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (mif.start) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    n = 0;
    for (int i = 1; i <= 5; i++) begin
      cyc();
      #1;
      if (intr) n++;
    end
    cyc();
    #1;
    checks++;
    if (!ok || n != 0 || intr !== 1'b1 || cause !== 2'b10 || sval !== keep) begin
      errors++;
      $display("FAIL timeout: ok=%0d early=%0d intr=%b cause=%b sval=%h want 1,0,1,10,%h",
               ok, n, intr, cause, sval, keep);
    end
    run_sample(16'd500, 0, w, ok);
    checks++;
    if (!ok || w != 2 || cause !== 2'b01) begin
      errors++;
      $display("FAIL timeout_next: ok=%0d wait=%0d cause=%b want 1,2,01",
               ok, w, cause);
    end
    tmo = '0;
    go_disabled();
  endtask
`endif

  task automatic test_reset_mid();
    bit ok;
    int n;
    preset = 32'd1;
    en = 1'b1;
    cyc();
    ok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (mif.start) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    cyc();
    rst = 1'b1;
    en = 1'b0;
    #1;
    checks++;
    if (!ok || sval !== 16'h0 || cause !== 2'b00 || intr !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: ok=%0d sval=%h cause=%b intr=%b want 1,0000,00,0",
               ok, sval, cause, intr);
    end
    cyc();
    rst = 1'b0;
    cyc();
    mif.done = 1'b1;
    mif.value = 16'hFFFF;
    cyc();
    mif.done = 1'b0;
    mif.value = '0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (intr || mif.start) n++;
      cyc();
    end
    checks++;
    if (n != 0 || sval !== 16'h0 || cause !== 2'b00) begin
      errors++;
      $display("FAIL rst_late_done: activity=%0d sval=%h cause=%b want 0,0000,00",
               n, sval, cause);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] smp [4];
    int w;
    bit ok;
    smp = '{16'd1, 16'd2, 16'd1, 16'd2};
    mode = 1'b0;
    thr = 16'd0;
    preset = 32'd0;
    en = 1'b1;
    cyc();
    for (int i = 0; i < 4; i++) begin
      run_sample(smp[i], 0, w, ok);
      checks++;
      if (!ok || w != (i == 0 ? 0 : 1) || intr !== 1'b1 || sval !== smp[i]) begin
        errors++;
        $display("FAIL b2b_s%0d: ok=%0d wait=%0d intr=%b sval=%0d want 1,%0d,1,%0d",
                 i, ok, w, intr, sval, (i == 0 ? 0 : 1), smp[i]);
      end
    end
    go_disabled();
  endtask

  initial begin
    test_reset();
    test_delta();
    test_window();
    test_enable_drop();
`ifdef SENSORFSM_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
